enemy_hit_detect: RTL
=====================

ENEMY_HIT_DETECT -- requirements
Module: enemy_hit_detect

Interface
REQ-001 SHALL have parameter GRID_COLS, default 7, enemy columns.
REQ-002 SHALL have parameter GRID_ROWS, default 3, enemy rows (row 0 easy, 1 medium, 2 hard).
REQ-003 SHALL have parameter CELL_W, default 73, column pitch in pixels.
REQ-004 SHALL have parameter CELL_H, default 50, row pitch in pixels.
REQ-005 SHALL have parameter SCORE_W, default 16, score width.
REQ-006 SHALL have one clock and an asynchronous active-low reset: Clk  input  1  system clock (50 MHz).
REQ-007 SHALL have Reset  input  1  asynchronous active-low reset.
REQ-008 SHALL have frame_clk  input  1  vsync-derived frame strobe, asynchronous to Clk.
REQ-009 SHALL have is_playing  input  1  game active; new_game  input  1  one-cycle reload pulse.
REQ-010 SHALL have DrawX, DrawY  input  10 each  current pixel.
REQ-011 SHALL have enemy_on, missile_on  input  1 each  pixel coverage from enemy array and missile.
REQ-012 SHALL have grid_x, grid_y  input  10 each  array top-left (enemy array L_Edge/U_Edge).
REQ-013 SHALL have hit  output  1  one-cycle kill pulse; hit_row  output  2; hit_col  output  3.
REQ-014 SHALL have alive_mask  output  GRID_ROWS*GRID_COLS  bit r*GRID_COLS+c = enemy alive.
REQ-015 SHALL have score  output  SCORE_W; all_cleared  output  1  alive_mask==0.

Function
REQ-016 SHALL synchronise frame_clk through two flops and form frame_edge on a registered rising edge.
REQ-017 SHALL implement states IDLE, SCAN, REPORT (and HOLD when configured).
REQ-018 IDLE SHALL go to SCAN on the first frame_edge with is_playing=1; any state SHALL go to IDLE when is_playing=0, dropping any pending capture.
REQ-019 In SCAN, a pixel with enemy_on & missile_on inside the grid and on an alive cell SHALL be captured (row, col) if nothing is captured yet this frame; later collisions in the frame SHALL be ignored (first in raster order wins).
REQ-020 Cell index SHALL be col = largest c with DrawX-grid_x >= c*CELL_W, row likewise with CELL_H; pixels with DrawX<grid_x, DrawY<grid_y, col>=GRID_COLS or row>=GRID_ROWS SHALL be ignored.
REQ-021 On frame_edge in SCAN with a capture, the FSM SHALL enter REPORT for exactly one cycle, asserting hit with hit_row/hit_col, clearing the alive bit and adding 10*(row+1) to score; without a capture it SHALL stay in SCAN.
REQ-022 hit_row/hit_col SHALL hold their last value until the next REPORT.
REQ-023 score SHALL saturate at all-ones, never wrap.
REQ-024 new_game SHALL set alive_mask to all ones, score to 0, clear capture, and take priority over a simultaneous REPORT.
REQ-025 all_cleared SHALL be combinational from alive_mask.

Reset
REQ-026 Reset low SHALL asynchronously force state IDLE, hit 0, hit_row 0, hit_col 0, score 0, alive_mask all ones, synchroniser flops 0, capture empty.

Configuration
REQ-027 With macro ENEMY_HIT_COOLDOWN_EN defined, REPORT SHALL go to HOLD, ignoring collisions for 4 frame_edges before returning to SCAN; undefined, REPORT SHALL return directly to SCAN and HOLD SHALL not exist.

Structure
REQ-028 Package space_invaders_pkg SHALL hold the state enum, GRID_COLS/GRID_ROWS/CELL_W/CELL_H defaults and the per-row point table.
REQ-029 Sub-module grid_locator SHALL map (DrawX, DrawY, grid_x, grid_y) to (row, col, in_grid) combinationally.

Verification
REQ-030 Reset, then is_playing=1, frame_edge -> state SCAN, alive_mask=0x1FFFFF, score=0.
REQ-031 grid_x=0, grid_y=0, collision at (80,60) then frame_edge -> one-cycle hit, row 1, col 1, bit 8 cleared, score=20.
REQ-032 Collisions at (10,10) then (160,110) in one frame -> only row 0 col 0 killed, score=10.
REQ-033 Repeat collision on an already-dead cell -> no hit, score unchanged.
REQ-034 score preloaded to 0xFFF0, hard-row kill -> score=0xFFFF.
REQ-035 Kill all 21 cells -> all_cleared=1; new_game on the same cycle as a REPORT -> alive_mask all ones, score 0, hit still pulsed.

Source files
------------

// File: rtl/space_invaders_pkg.sv
// Shared types and defaults for the enemy hit detector.
// ENEMY_HIT_COOLDOWN_EN adds the HOLD state to the FSM encoding.
package space_invaders_pkg;

    localparam int DEF_GRID_COLS = 7;
    localparam int DEF_GRID_ROWS = 3;
    localparam int DEF_CELL_W    = 73;
    localparam int DEF_CELL_H    = 50;
    localparam int HOLD_FRAMES   = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT
`ifdef ENEMY_HIT_COOLDOWN_EN
        , HOLD
`endif
    } hit_state_t;

    // Points awarded per row: easy, medium, hard.
    function automatic logic [7:0] row_points(input logic [1:0] row);
        logic [7:0] pts;
        case (row)
            2'd0:    pts = 8'd10;
            2'd1:    pts = 8'd20;
            2'd2:    pts = 8'd30;
            default: pts = 8'd0;
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/grid_locator.sv
// Maps the current pixel onto an enemy grid cell relative to the array's top-left.
// Purely combinational; in_grid qualifies row/col.
module grid_locator
    import space_invaders_pkg::*;
#(
    parameter int GRID_COLS = DEF_GRID_COLS,
    parameter int GRID_ROWS = DEF_GRID_ROWS,
    parameter int CELL_W    = DEF_CELL_W,
    parameter int CELL_H    = DEF_CELL_H
)(
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] grid_x,
    input  logic [9:0] grid_y,
    output logic [1:0] row,
    output logic [2:0] col,
    output logic       in_grid
);

    logic [10:0] dx;
    logic [10:0] dy;

    always_comb begin
        // Bit 10 is the borrow: set when the pixel is left of / above the array.
        dx  = {1'b0, DrawX} - {1'b0, grid_x};
        dy  = {1'b0, DrawY} - {1'b0, grid_y};
        col = '0;
        row = '0;
        for (int c = 1; c < GRID_COLS; c++) begin
            if (int'(dx[9:0]) >= c * CELL_W) col = 3'(c);
        end
        for (int r = 1; r < GRID_ROWS; r++) begin
            if (int'(dy[9:0]) >= r * CELL_H) row = 2'(r);
        end
        in_grid = !dx[10] && !dy[10]
               && (int'(dx[9:0]) < GRID_COLS * CELL_W)
               && (int'(dy[9:0]) < GRID_ROWS * CELL_H);
    end

endmodule

// File: rtl/enemy_hit_detect.sv
// Detects missile/enemy pixel overlap per frame and reports at most one kill per frame.
// Define ENEMY_HIT_COOLDOWN_EN to add a 4-frame HOLD after every kill.
//
// state  | meaning
// IDLE   | game not running, waiting for first frame edge while playing
// SCAN   | watching pixels for the first collision of the frame
// REPORT | one-cycle kill pulse, alive bit cleared and score updated
// HOLD   | cooldown, collisions ignored for 4 frame edges (optional)
module enemy_hit_detect
    import space_invaders_pkg::*;
#(
    parameter int GRID_COLS = DEF_GRID_COLS,
    parameter int GRID_ROWS = DEF_GRID_ROWS,
    parameter int CELL_W    = DEF_CELL_W,
    parameter int CELL_H    = DEF_CELL_H,
    parameter int SCORE_W   = 16
)(
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           frame_clk,
    input  logic                           is_playing,
    input  logic                           new_game,
    input  logic [9:0]                     DrawX,
    input  logic [9:0]                     DrawY,
    input  logic                           enemy_on,
    input  logic                           missile_on,
    input  logic [9:0]                     grid_x,
    input  logic [9:0]                     grid_y,
    output logic                           hit,
    output logic [1:0]                     hit_row,
    output logic [2:0]                     hit_col,
    output logic [GRID_ROWS*GRID_COLS-1:0] alive_mask,
    output logic [SCORE_W-1:0]             score,
    output logic                           all_cleared
);

    localparam int CELLS = GRID_ROWS * GRID_COLS;

    hit_state_t state, state_next;

    logic [2:0]         sync_q;
    logic               frame_edge;
    logic [1:0]         loc_row;
    logic [2:0]         loc_col;
    logic               loc_in_grid;
    int                 loc_idx;
    int                 hit_idx;
    logic               cell_alive;
    logic               cap_valid;
    logic [1:0]         cap_row;
    logic [2:0]         cap_col;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_next;
`ifdef ENEMY_HIT_COOLDOWN_EN
    logic [1:0]         hold_cnt;
`endif

    // frame_clk is asynchronous: two flops to settle, a third for edge detect.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) sync_q <= '0;
        else        sync_q <= {sync_q[1:0], frame_clk};
    end

    assign frame_edge = sync_q[1] & ~sync_q[2];

    grid_locator #(
        .GRID_COLS (GRID_COLS),
        .GRID_ROWS (GRID_ROWS),
        .CELL_W    (CELL_W),
        .CELL_H    (CELL_H)
    ) u_grid_locator (
        .DrawX   (DrawX),
        .DrawY   (DrawY),
        .grid_x  (grid_x),
        .grid_y  (grid_y),
        .row     (loc_row),
        .col     (loc_col),
        .in_grid (loc_in_grid)
    );

    always_comb begin
        loc_idx    = int'(loc_row) * GRID_COLS + int'(loc_col);
        hit_idx    = int'(hit_row) * GRID_COLS + int'(hit_col);
        cell_alive = |(alive_mask & (CELLS'(1) << loc_idx));
        score_sum  = {1'b0, score} + {{(SCORE_W - 7){1'b0}}, row_points(hit_row)};
        score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    end

    assign all_cleared = ~|alive_mask;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!is_playing) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (frame_edge) state_next = SCAN;
                SCAN:    if (frame_edge && cap_valid) state_next = REPORT;
`ifdef ENEMY_HIT_COOLDOWN_EN
                REPORT:  state_next = HOLD;
                HOLD:    if (frame_edge && hold_cnt == 2'd0) state_next = SCAN;
`else
                REPORT:  state_next = SCAN;
`endif
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        hit = (state == REPORT);
    end

    // Capture the first collision of a frame; the frame edge both consumes and clears it.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cap_valid <= 1'b0;
            cap_row   <= '0;
            cap_col   <= '0;
        end else if (new_game || !is_playing || state != SCAN || frame_edge) begin
            cap_valid <= 1'b0;
        end else if (!cap_valid && enemy_on && missile_on && loc_in_grid && cell_alive) begin
            cap_valid <= 1'b1;
            cap_row   <= loc_row;
            cap_col   <= loc_col;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hit_row <= '0;
            hit_col <= '0;
        end else if (is_playing && state == SCAN && frame_edge && cap_valid) begin
            hit_row <= cap_row;
            hit_col <= cap_col;
        end
    end

    // new_game wins over the bookkeeping of a coincident REPORT.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            alive_mask <= '1;
            score      <= '0;
        end else if (new_game) begin
            alive_mask <= '1;
            score      <= '0;
        end else if (state == REPORT) begin
            alive_mask <= alive_mask & ~(CELLS'(1) << hit_idx);
            score      <= score_next;
        end
    end

`ifdef ENEMY_HIT_COOLDOWN_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hold_cnt <= '0;
        end else if (state == REPORT) begin
            hold_cnt <= 2'(HOLD_FRAMES - 1);
        end else if (state == HOLD && frame_edge && hold_cnt != 2'd0) begin
            hold_cnt <= hold_cnt - 2'd1;
        end
    end
`endif

endmodule
